// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the Gray frame sequencer: FSM state encoding,
// frame length and word width.
package gray_seq_pkg;
    localparam int FRAME_LEN = 5;
    localparam int WORD_W    = 5;
    localparam int SHIFT_LEN = FRAME_LEN - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;
endpackage

// File: rtl/bin_gray_5bit.sv
// Combinational binary-to-Gray converter for one sequencer word.
module bin_gray_5bit
    import gray_seq_pkg::*;
(
    input  logic [WORD_W-1:0] i_bin,
    output logic [WORD_W-1:0] o_gray
);
    assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/gray_frame_sequencer.sv
// Feeds a 5-bit PISO: one-entry input buffer, LOAD/SHIFT/GAP framing, frame counter.
// Define SEQ_BIN2GRAY_EN to Gray-encode each word before it is loaded.
module gray_frame_sequencer
    import gray_seq_pkg::*;
#(
    parameter int GAP   = 0,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [WORD_W-1:0] word_out,
    output logic              shift,
    output logic              frame_start,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);
    state_t             r_state;
    state_t             w_next;
    logic [WORD_W-1:0]  r_buf;
    logic [WORD_W-1:0]  r_word;
    logic [WORD_W-1:0]  w_conv;
    logic               r_buf_full;
    logic [3:0]         r_ph;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_load;
    logic               w_accept;

`ifdef SEQ_BIN2GRAY_EN
    bin_gray_5bit u_b2g (
        .i_bin  (r_buf),
        .o_gray (w_conv)
    );
`else
    assign w_conv = r_buf;
`endif

    assign w_load   = (r_state == ST_LOAD);
    // The buffer drains in LOAD, so a refill that same cycle avoids a bubble.
    assign in_ready = !r_buf_full || w_load;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_buf_full || w_accept) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_SHIFT;
            ST_SHIFT: begin
                if (r_ph == 4'(SHIFT_LEN - 1)) begin
                    if (GAP > 0)         w_next = ST_GAP;
                    else if (r_buf_full) w_next = ST_LOAD;
                    else                 w_next = ST_IDLE;
                end
            end
            ST_GAP:   if (r_ph == 4'(GAP - 1)) w_next = r_buf_full ? ST_LOAD : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_word     <= '0;
            r_ph       <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            r_ph    <= (w_next != r_state) ? 4'd0 : r_ph + 4'd1;
            if (w_accept) begin
                r_buf      <= in_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end
            if (w_load) r_word <= w_conv;
            // Counted on entry so frame_cnt already shows the new frame during LOAD.
            if (w_next == ST_LOAD) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign word_out    = w_load ? w_conv : r_word;
    assign shift       = !w_load;
    assign frame_start = w_load;
    assign busy        = (r_state != ST_IDLE);
    assign frame_cnt   = r_cnt;
endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Scoreboard bench for gray_frame_sequencer: a GAP=0 and a GAP=3 instance share clock/reset.
module tb_gray_frame_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v3 = 1'b0;
    logic [4:0] d0 = '0, d3 = '0;
    logic       rdy0, sh0, fs0, bz0, rdy3, sh3, fs3, bz3;
    logic [4:0] wo0, wo3;
    logic [7:0] fc0, fc3;

    gray_frame_sequencer #(.GAP(0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
        .word_out(wo0), .shift(sh0), .frame_start(fs0), .busy(bz0), .frame_cnt(fc0));
    gray_frame_sequencer #(.GAP(3), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
        .word_out(wo3), .shift(sh3), .frame_start(fs3), .busy(bz3), .frame_cnt(fc3));

    always #5 clk = ~clk;

    typedef struct { logic [4:0] w; logic [7:0] c; } exp_t;
    exp_t       q0[$], q3[$];
    int         ld0[$], ld3[$];
    logic [7:0] mc0 = '0, mc3 = '0;
    logic [4:0] lw0 = '0, lw3 = '0;
    int         sl0 = 100, sl3 = 100;
    int         cyc = 0;
    int         n_chk = 0, n_err = 0;

    function automatic logic [4:0] model_word(input logic [4:0] b);
`ifdef SEQ_BIN2GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    function automatic logic [4:0] gray2bin(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon0
        exp_t e0;
        if (fs0) begin
            sl0 = 0;
            ld0.push_back(cyc);
            chk("load_shift0", sh0, 0);
            if (q0.size() == 0) chk("unexp_load0", 1, 0);
            else begin
                e0 = q0.pop_front();
                lw0 = e0.w;
                chk("word0", wo0, e0.w);
                chk("cnt0", fc0, e0.c);
            end
        end else begin
            if (sl0 < 1000) sl0++;
            if (sl0 >= 1 && sl0 <= 4) begin
                chk("shift0", sh0, 1);
                chk("busy0", bz0, 1);
                chk("hold0", wo0, lw0);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e3;
        if (fs3) begin
            sl3 = 0;
            ld3.push_back(cyc);
            chk("load_shift3", sh3, 0);
            if (q3.size() == 0) chk("unexp_load3", 1, 0);
            else begin
                e3 = q3.pop_front();
                lw3 = e3.w;
                chk("word3", wo3, e3.w);
                chk("cnt3", fc3, e3.c);
            end
        end else begin
            if (sl3 < 1000) sl3++;
            if (sl3 >= 1 && sl3 <= 7) begin
                chk("shift3", sh3, 1);
                chk("busy3", bz3, 1);
                chk("hold3", wo3, lw3);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        v0 = 1'b0;
        v3 = 1'b0;
        tick;
        rst = 1'b0;
        q0.delete(); q3.delete(); ld0.delete(); ld3.delete();
        mc0 = '0; mc3 = '0; sl0 = 100; sl3 = 100;
    endtask

    task automatic send(input int sel, input logic [4:0] w);
        int n = 0;
        bit acc = 1'b0;
        if (sel == 0) begin d0 = w; v0 = 1'b1; end
        else          begin d3 = w; v3 = 1'b1; end
        while (!acc && n < 60) begin
            acc = (sel == 0) ? rdy0 : rdy3;
            if (acc) begin
                if (sel == 0) begin mc0++; q0.push_back('{w: model_word(w), c: mc0}); end
                else          begin mc3++; q3.push_back('{w: model_word(w), c: mc3}); end
            end
            tick;
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        if (sel == 0) v0 = 1'b0; else v3 = 1'b0;
    endtask

    task automatic wait_fs(input int sel, input string tag);
        int n = 0;
        while (!((sel == 0) ? fs0 : fs3) && n < 60) begin
            tick;
            n++;
        end
        chk(tag, (sel == 0) ? fs0 : fs3, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        do_reset;
        chk("rst_ready", rdy0, 1);
        chk("rst_busy", bz0, 0);
        chk("rst_shift", sh0, 1);
        chk("rst_fs", fs0, 0);
        chk("rst_word", wo0, 0);
        chk("rst_cnt", fc0, 0);
        chk("rst_ready3", rdy3, 1);

        // single frame
        send(0, 5'b10110);
        chk("t1_shift", sh0, 0);
        chk("t1_fs", fs0, 1);
        chk("t1_word", wo0, model_word(5'b10110));
        chk("t1_cnt", fc0, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t1_sh", sh0, 1);
            chk("t1_fs_lo", fs0, 0);
        end
        tick;
        chk("t1_idle", bz0, 0);

        // back-to-back frames, GAP=0
        do_reset;
        send(0, 5'b00011);
        send(0, 5'b11100);
        chk("b2b_ready_low", rdy0, 0);
        wait_fs(0, "b2b_load2");
        chk("b2b_ready_back", rdy0, 1);
        chk("b2b_cnt", fc0, 2);
        repeat (6) tick;
        chk("b2b_nload", ld0.size(), 2);
        if (ld0.size() == 2) chk("b2b_space", ld0[1] - ld0[0], 5);

        // GAP=3 stream
        do_reset;
        send(3, 5'b00001);
        send(3, 5'b10010);
        send(3, 5'b01111);
        wait_fs(3, "gap_load3");
        repeat (5) tick;
        chk("gap_shift", sh3, 1);
        chk("gap_busy", bz3, 1);
        repeat (3) tick;
        chk("gap_idle", bz3, 0);
        chk("gap_nload", ld3.size(), 3);
        if (ld3.size() == 3) begin
            chk("gap_space1", ld3[1] - ld3[0], 8);
            chk("gap_space2", ld3[2] - ld3[1], 8);
        end
        chk("gap_cnt", fc3, 3);

        // reset mid-frame with a full buffer
        do_reset;
        send(0, 5'b10101);
        send(0, 5'b01010);
        chk("mr_full", rdy0, 0);
        tick;
        tick;
        do_reset;
        chk("mr_ready", rdy0, 1);
        chk("mr_busy", bz0, 0);
        chk("mr_cnt", fc0, 0);
        chk("mr_word", wo0, 0);
        repeat (12) tick;
        chk("mr_noload", ld0.size(), 0);

        // counter wrap after 256 frames
        do_reset;
        for (int k = 0; k < 256; k++) send(0, 5'(k));
        wait_fs(0, "wrap_load");
        chk("wrap_cnt", fc0, 0);
        repeat (6) tick;
        chk("wrap_nload", ld0.size(), 256);

        // optional Gray conversion
        do_reset;
        send(0, 5'b01101);
`ifdef SEQ_BIN2GRAY_EN
        chk("g_word", wo0, 5'b01011);
        chk("g_round", gray2bin(wo0), 5'b01101);
`else
        chk("g_word", wo0, 5'b01101);
`endif
        repeat (6) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
